// File: rtl/reaction_signal_ctrl_pkg.sv
// Shared encodings for the reaction-timer control slice: StateMachine states,
// player ids, event-vector bit positions and the reaction saturation point.
package reaction_signal_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_CLR_CNT1 = 3'd2,
    ST_START    = 3'd3,
    ST_STORAGE  = 3'd4,
    ST_CLR_CNT2 = 3'd5,
    ST_AVERAGE  = 3'd6,
    ST_COMPARE  = 3'd7
  } mstate_e;

  localparam logic PLAYER_A = 1'b1;
  localparam logic PLAYER_B = 1'b0;

  localparam int SIG_ACTION   = 6;
  localparam int SIG_REACT    = 5;
  localparam int SIG_AVERAGE  = 4;
  localparam int SIG_COMPARE  = 3;
  localparam int SIG_START    = 2;
  localparam int SIG_OVERFLOW = 1;
  localparam int SIG_CLEARED  = 0;

  localparam int MAX_REACT_MS = 999;

  // x^10 + x^7 + 1 Fibonacci step; the all-zero state is unreachable from a non-zero seed.
  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

endpackage

// File: rtl/reaction_signal_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, then a level that only follows the
// input after it has differed for DEBOUNCE_MS ms ticks; press pulses on accepted rises.
module reaction_signal_ctrl_btn_debounce #(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      press_q <= 1'b0;
      // any bounce back to the accepted level restarts the stability window
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (ms_tick_i) begin
        if (cnt_q == CNT_MAX) begin
          level_q <= sync_q[1];
          press_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/reaction_signal_ctrl.sv
// Event generator for the reaction-timer StateMachine: random WAIT delay, ms reaction
// counter, player selection, and one registered pulse per state visit.
module reaction_signal_ctrl
  import reaction_signal_ctrl_pkg::*;
#(
  parameter int         MS_DIV       = 12000,
  parameter int         DEBOUNCE_MS  = 10,
  parameter int         DELAY_MIN_MS = 1000,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] machine_state,
  input  logic [2:0] test_turn_A,
  input  logic [2:0] test_turn_B,
  input  logic       btn_start,
  input  logic       btn_react,
  output logic [6:0] signals,
  output logic [9:0] react_time,
  output logic       cur_player
);
  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);
  localparam logic [9:0]    MAX_RT    = 10'(MAX_REACT_MS);

  logic [PW-1:0] presc_q, presc_d;
  logic          ms_tick;
  logic [9:0]    lfsr_q;
  mstate_e       st, prev_q;
  logic          entry;
  logic          armed_q, armed_d;
  logic [10:0]   delay_q, delay_d, delay_load;
  logic [9:0]    cnt_q, cnt_d;
  logic [6:0]    sig_q, sig_d;
  logic [9:0]    rt_q, rt_d;
  logic          cur_q, cur_d;
  logic [2:0]    turn_cur, turn_oth;
  logic [1:0]    btn_raw, press, lvl_unused;

  assign st         = mstate_e'(machine_state);
  assign entry      = (st != prev_q);
  assign ms_tick    = (presc_q == PRESC_MAX);
  assign delay_load = 11'(DELAY_MIN_MS) + {1'b0, lfsr_q};
  assign turn_cur   = cur_q ? test_turn_A : test_turn_B;
  assign turn_oth   = cur_q ? test_turn_B : test_turn_A;
  assign btn_raw    = {btn_react, btn_start};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    reaction_signal_ctrl_btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clk      (clk),
      .rst      (rst),
      .ms_tick_i(ms_tick),
      .btn_i    (btn_raw[i]),
      .level_o  (lvl_unused[i]),
      .press_o  (press[i])
    );
  end

  always_comb begin
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
    armed_d = armed_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;
    sig_d   = '0;
    rt_d    = rt_q;
    cur_d   = cur_q;
    if (entry) begin
      presc_d = '0;
      armed_d = 1'b1;
      delay_d = delay_load;
      cnt_d   = '0;
    end else begin
      if (ms_tick && st == ST_WAIT && delay_q != '0) delay_d = delay_q - 11'd1;
      if (ms_tick && st == ST_START && cnt_q != MAX_RT) cnt_d = cnt_q + 10'd1;
      if (armed_q) begin
        case (st)
          ST_IDLE: if (press[0]) begin
            sig_d[SIG_ACTION] = 1'b1;
            armed_d           = 1'b0;
          end
          // false start re-randomises the delay and stays armed
          ST_WAIT: if (press[1]) begin
            delay_d = delay_load;
          end else if (delay_q == '0) begin
            sig_d[SIG_START] = 1'b1;
            armed_d          = 1'b0;
          end
          ST_CLR_CNT1, ST_CLR_CNT2: begin
            sig_d[SIG_CLEARED] = 1'b1;
            cnt_d              = '0;
            armed_d            = 1'b0;
          end
          ST_START: if (press[1]) begin
            rt_d             = cnt_q;
            sig_d[SIG_REACT] = 1'b1;
            armed_d          = 1'b0;
          end else if (cnt_q == MAX_RT) begin
            rt_d                = MAX_RT;
            sig_d[SIG_REACT]    = 1'b1;
            sig_d[SIG_OVERFLOW] = 1'b1;
            armed_d             = 1'b0;
          end
          ST_STORAGE: begin
            if (turn_cur == 3'd7) sig_d[SIG_AVERAGE] = 1'b1;
            else                  sig_d[SIG_ACTION]  = 1'b1;
            armed_d = 1'b0;
          end
          ST_AVERAGE: begin
            if (test_turn_A == 3'd7 && test_turn_B == 3'd7) begin
              sig_d[SIG_COMPARE] = 1'b1;
            end else begin
              if (turn_oth != 3'd7) cur_d = ~cur_q;
              sig_d[SIG_ACTION] = 1'b1;
            end
            armed_d = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      lfsr_q  <= LFSR_SEED;
      prev_q  <= ST_IDLE;
      armed_q <= 1'b1;
      delay_q <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      rt_q    <= '0;
      cur_q   <= PLAYER_A;
    end else begin
      presc_q <= presc_d;
      lfsr_q  <= lfsr_next(lfsr_q);
      prev_q  <= st;
      armed_q <= armed_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      rt_q    <= rt_d;
      cur_q   <= cur_d;
    end
  end

  assign signals    = sig_q;
  assign react_time = rt_q;
  assign cur_player = cur_q;

endmodule
